// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin, packet-aware arbiter sharing the FIFO write
//                port between two producers, with a per-tenure burst cap
//                and combinational back-pressure on wfull.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 wclk,
    input  logic                 wrst_n,
    input  logic                 req0_valid,
    input  logic [DATA_SIZE-1:0] req0_data,
    input  logic                 req0_last,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [DATA_SIZE-1:0] req1_data,
    input  logic                 req1_last,
    output logic                 req1_ready,
    input  logic                 wfull,
    output logic                 wclk_en,
    output logic [DATA_SIZE-1:0] wdata,
    output logic [1:0]           grant
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_G0        = 2'd1;
    localparam logic [1:0] c_G1        = 2'd2;
    localparam logic [7:0] c_LAST_BEAT = 8'(MAX_BURST - 1);

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       r_rr_last;
    logic [7:0] r_beat_cnt;

    logic w_in_g0;
    logic w_in_g1;
    logic w_own_valid;
    logic w_own_last;
    logic w_transfer;
    logic w_release;

    assign w_in_g0     = (r_state == c_G0);
    assign w_in_g1     = (r_state == c_G1);
    assign w_own_valid = w_in_g0 ? req0_valid : (w_in_g1 ? req1_valid : 1'b0);
    assign w_own_last  = w_in_g0 ? req0_last  : (w_in_g1 ? req1_last  : 1'b0);
    // A word moves only with reset released, a grant held, the owner valid
    // and room in the FIFO; reset blocks the in-flight word.
    assign w_transfer  = wrst_n && (w_in_g0 || w_in_g1) && w_own_valid && !wfull;
    // Tenure ends on the packet's last word or when the burst cap is reached.
    assign w_release   = w_transfer && (w_own_last || (r_beat_cnt == c_LAST_BEAT));

    // State register.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Round-robin history and beat counter for the current tenure.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            r_rr_last  <= 1'b1;
            r_beat_cnt <= 8'd0;
        end else if (r_state == c_IDLE) begin
            r_beat_cnt <= 8'd0;
        end else if (w_release) begin
            r_rr_last  <= w_in_g1;
            r_beat_cnt <= 8'd0;
        end else if (w_transfer) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
        end
    end

    // Next-state logic: arbitrate in IDLE, hand over without a bubble on release.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (req0_valid && req1_valid) begin
                    w_next_state = r_rr_last ? c_G0 : c_G1;
                end else if (req0_valid) begin
                    w_next_state = c_G0;
                end else if (req1_valid) begin
                    w_next_state = c_G1;
                end
            end
            c_G0: begin
                if (w_release) begin
                    w_next_state = req1_valid ? c_G1 : c_IDLE;
                end
            end
            c_G1: begin
                if (w_release) begin
                    w_next_state = req0_valid ? c_G0 : c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Output decode; everything is held at zero while reset is asserted.
    always_comb begin
        grant      = 2'b00;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        wdata      = '0;
        wclk_en    = w_transfer;
        if (wrst_n) begin
            case (r_state)
                c_G0: begin
                    grant      = 2'b01;
                    req0_ready = !wfull;
                    wdata      = req0_data;
                end
                c_G1: begin
                    grant      = 2'b10;
                    req1_ready = !wfull;
                    wdata      = req1_data;
                end
                default: begin
                    grant = 2'b00;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Directed self-checking bench for fifo_wr_arbiter
//                (MAX_BURST=4 main instance, MAX_BURST=1 alternation instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    logic       wclk = 1'b0;
    logic       wrst_n;
    logic       req0_valid, req0_last, req0_ready;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req0_data, req1_data, wdata;
    logic       wfull, wclk_en;
    logic [1:0] grant;

    logic       b_req0_valid = 1'b0, b_req0_last = 1'b0, b_req0_ready;
    logic       b_req1_valid = 1'b0, b_req1_last = 1'b0, b_req1_ready;
    logic [7:0] b_req0_data = 8'd0, b_req1_data = 8'd0, b_wdata;
    logic       b_wfull = 1'b0, b_wclk_en;
    logic [1:0] b_grant;

    int checks = 0;
    int errors = 0;

    // Producer model: word tables, index of next word, enable per requester.
    logic [7:0] w0 [8];
    logic [7:0] w1 [8];
    logic       l0 [8];
    logic       l1 [8];
    int         n0, n1, i0, i1;
    bit         en0, en1;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(.DATA_SIZE(8), .MAX_BURST(4)) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last),
        .req1_ready(req1_ready),
        .wfull(wfull), .wclk_en(wclk_en), .wdata(wdata), .grant(grant)
    );

    fifo_wr_arbiter #(.DATA_SIZE(8), .MAX_BURST(1)) dut1 (
        .wclk(wclk), .wrst_n(wrst_n),
        .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_last(b_req0_last),
        .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_last(b_req1_last),
        .req1_ready(b_req1_ready),
        .wfull(b_wfull), .wclk_en(b_wclk_en), .wdata(b_wdata), .grant(b_grant)
    );

    task automatic drive();
        req0_valid = en0 && (i0 < n0);
        req0_data  = (i0 < n0) ? w0[i0] : 8'd0;
        req0_last  = (i0 < n0) ? l0[i0] : 1'b0;
        req1_valid = en1 && (i1 < n1);
        req1_data  = (i1 < n1) ? w1[i1] : 8'd0;
        req1_last  = (i1 < n1) ? l1[i1] : 1'b0;
    endtask

    task automatic step();
        bit h0, h1;
        h0 = req0_valid && req0_ready;
        h1 = req1_valid && req1_ready;
        @(posedge wclk);
        #1;
        if (h0) i0++;
        if (h1) i1++;
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        wfull  = 1'b0;
        en0 = 0; en1 = 0; n0 = 0; n1 = 0; i0 = 0; i1 = 0;
        drive();
        step();
        step();
        wrst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        wrst_n = 1'b0;
        w0 = '{8'h5A, 0, 0, 0, 0, 0, 0, 0};
        l0 = '{1, 0, 0, 0, 0, 0, 0, 0};
        w1 = '{8'hA5, 0, 0, 0, 0, 0, 0, 0};
        l1 = '{1, 0, 0, 0, 0, 0, 0, 0};
        n0 = 1; n1 = 1; en0 = 1; en1 = 1;
        for (int c = 0; c < 2; c++) begin
            drive();
            #2;
            checks++;
            if ({grant, req0_ready, req1_ready, wclk_en, wdata} !== 13'd0) begin
                errors++;
                $display("FAIL reset_outputs cyc %0d: grant=%b rdy=%b%b en=%b wdata=%h, expected all zero",
                         c, grant, req0_ready, req1_ready, wclk_en, wdata);
            end
            step();
        end
        checks++;
        if (dut.r_rr_last !== 1'b1 || dut.r_beat_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: rr_last=%b beat_cnt=%0d, expected rr_last=1 beat_cnt=0",
                     dut.r_rr_last, dut.r_beat_cnt);
        end
    endtask

    task automatic test_single_packet();
        logic [1:0] eg [6] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        logic       ee [6] = '{0, 1, 1, 1, 0, 0};
        logic [7:0] ed [6] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00};
        do_reset();
        w0 = '{8'h11, 8'h22, 8'h33, 0, 0, 0, 0, 0};
        l0 = '{0, 0, 1, 0, 0, 0, 0, 0};
        n0 = 3; en0 = 1;
        for (int c = 0; c < 6; c++) begin
            drive();
            #2;
            checks++;
            if (grant !== eg[c] || wclk_en !== ee[c] || (ee[c] && wdata !== ed[c])) begin
                errors++;
                $display("FAIL single_packet cyc %0d: grant=%b en=%b wdata=%h, expected grant=%b en=%b wdata=%h",
                         c, grant, wclk_en, wdata, eg[c], ee[c], ed[c]);
            end
            if (c == 4) begin
                checks++;
                if (dut.r_rr_last !== 1'b0) begin
                    errors++;
                    $display("FAIL single_rr_last: rr_last=%b, expected 0", dut.r_rr_last);
                end
            end
            step();
        end
    endtask

    task automatic test_burst_cap();
        logic [1:0] eg [14] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10,
                                2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
        logic [7:0] ed [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h81, 8'h82,
                                8'h83, 8'h84, 8'h05, 8'h06, 8'h85, 8'h86, 8'h00};
        logic       ee;
        do_reset();
        w0 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 0, 0};
        l0 = '{0, 0, 0, 0, 0, 1, 0, 0};
        w1 = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 0, 0};
        l1 = '{0, 0, 0, 0, 0, 1, 0, 0};
        n0 = 6; n1 = 6; en0 = 1; en1 = 1;
        for (int c = 0; c < 14; c++) begin
            ee = (c >= 1 && c <= 12);
            drive();
            #2;
            checks++;
            if (grant !== eg[c] || wclk_en !== ee || (ee && wdata !== ed[c])) begin
                errors++;
                $display("FAIL burst_cap cyc %0d: grant=%b en=%b wdata=%h, expected grant=%b en=%b wdata=%h",
                         c, grant, wclk_en, wdata, eg[c], ee, ed[c]);
            end
            step();
        end
        checks++;
        if (i0 != 6 || i1 != 6) begin
            errors++;
            $display("FAIL burst_cap_count: accepted %0d/%0d, expected 6/6", i0, i1);
        end
    endtask

    task automatic test_alternate();
        int         k0, k1;
        bit         h0, h1;
        logic [1:0] eg;
        logic [7:0] ed;
        logic       ee;
        do_reset();
        k0 = 0; k1 = 0;
        for (int c = 0; c < 9; c++) begin
            b_req0_valid = 1'b1;
            b_req1_valid = 1'b1;
            b_req0_data  = 8'(8'hA0 + k0);
            b_req1_data  = 8'(8'hB0 + k1);
            ee = (c >= 1);
            eg = (c == 0) ? 2'b00 : ((c % 2 == 1) ? 2'b01 : 2'b10);
            ed = (c % 2 == 1) ? 8'(8'hA0 + (c - 1) / 2) : 8'(8'hB0 + (c - 2) / 2);
            #2;
            checks++;
            if (b_grant !== eg || b_wclk_en !== ee || (ee && b_wdata !== ed)) begin
                errors++;
                $display("FAIL alternate cyc %0d: grant=%b en=%b wdata=%h, expected grant=%b en=%b wdata=%h",
                         c, b_grant, b_wclk_en, b_wdata, eg, ee, ed);
            end
            h0 = b_req0_valid && b_req0_ready;
            h1 = b_req1_valid && b_req1_ready;
            @(posedge wclk);
            #1;
            if (h0) k0++;
            if (h1) k1++;
        end
        b_req0_valid = 1'b0;
        b_req1_valid = 1'b0;
    endtask

    task automatic test_wfull_stall();
        logic       ef [9] = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        logic       ee [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
        logic [1:0] eg [9] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        logic [7:0] ed [9] = '{8'h00, 8'hC1, 8'hC2, 8'h00, 8'h00, 8'h00, 8'hC3, 8'hC4, 8'h00};
        do_reset();
        w1 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 0, 0, 0, 0};
        l1 = '{0, 0, 0, 1, 0, 0, 0, 0};
        n1 = 4; en1 = 1;
        for (int c = 0; c < 9; c++) begin
            wfull = ef[c];
            drive();
            #2;
            checks++;
            if (grant !== eg[c] || wclk_en !== ee[c] || (ee[c] && wdata !== ed[c])) begin
                errors++;
                $display("FAIL wfull_stall cyc %0d: grant=%b en=%b wdata=%h, expected grant=%b en=%b wdata=%h",
                         c, grant, wclk_en, wdata, eg[c], ee[c], ed[c]);
            end
            if (ef[c]) begin
                checks++;
                if (req1_ready !== 1'b0 || dut.r_beat_cnt !== 8'd2) begin
                    errors++;
                    $display("FAIL wfull_freeze cyc %0d: ready=%b beat_cnt=%0d, expected ready=0 beat_cnt=2",
                             c, req1_ready, dut.r_beat_cnt);
                end
            end
            step();
        end
        wfull = 1'b0;
        checks++;
        if (i1 != 4) begin
            errors++;
            $display("FAIL wfull_count: accepted %0d, expected 4", i1);
        end
    endtask

    task automatic test_reset_mid_tenure();
        logic       er [6] = '{1, 1, 1, 0, 1, 1};
        logic       ee [6] = '{0, 1, 1, 0, 0, 1};
        logic [1:0] eg [6] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
        logic [7:0] ed [6] = '{8'h00, 8'h51, 8'h52, 8'h00, 8'h00, 8'h53};
        do_reset();
        w0 = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 0, 0};
        l0 = '{0, 0, 0, 0, 0, 1, 0, 0};
        w1 = '{8'h61, 8'h62, 0, 0, 0, 0, 0, 0};
        l1 = '{0, 1, 0, 0, 0, 0, 0, 0};
        n0 = 6; n1 = 2; en0 = 1;
        for (int c = 0; c < 6; c++) begin
            wrst_n = er[c];
            en1    = (c >= 4);
            drive();
            #2;
            checks++;
            if (grant !== eg[c] || wclk_en !== ee[c] || (ee[c] && wdata !== ed[c])) begin
                errors++;
                $display("FAIL reset_mid cyc %0d: grant=%b en=%b wdata=%h, expected grant=%b en=%b wdata=%h",
                         c, grant, wclk_en, wdata, eg[c], ee[c], ed[c]);
            end
            if (c == 4) begin
                checks++;
                if (dut.r_rr_last !== 1'b1 || i0 != 2) begin
                    errors++;
                    $display("FAIL reset_mid_state: rr_last=%b accepted=%0d, expected rr_last=1 accepted=2",
                             dut.r_rr_last, i0);
                end
            end
            step();
        end
        wrst_n = 1'b1;
    endtask

    task automatic test_bubble_hold();
        logic       ee [10] = '{0, 1, 1, 0, 0, 1, 1, 1, 1, 0};
        logic [1:0] eg [10] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                                2'b01, 2'b10, 2'b10, 2'b00};
        logic [7:0] ed [10] = '{8'h00, 8'h71, 8'h72, 8'h00, 8'h00, 8'h73,
                                8'h74, 8'h91, 8'h92, 8'h00};
        do_reset();
        w0 = '{8'h71, 8'h72, 8'h73, 8'h74, 0, 0, 0, 0};
        l0 = '{0, 0, 0, 1, 0, 0, 0, 0};
        w1 = '{8'h91, 8'h92, 0, 0, 0, 0, 0, 0};
        l1 = '{0, 1, 0, 0, 0, 0, 0, 0};
        n0 = 4; n1 = 2; en1 = 1;
        for (int c = 0; c < 10; c++) begin
            en0 = !(c == 3 || c == 4);
            drive();
            #2;
            checks++;
            if (grant !== eg[c] || wclk_en !== ee[c] || (ee[c] && wdata !== ed[c])) begin
                errors++;
                $display("FAIL bubble_hold cyc %0d: grant=%b en=%b wdata=%h, expected grant=%b en=%b wdata=%h",
                         c, grant, wclk_en, wdata, eg[c], ee[c], ed[c]);
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (req1_ready !== 1'b0 || req0_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL bubble_ready cyc %0d: rdy0=%b rdy1=%b, expected rdy0=1 rdy1=0",
                             c, req0_ready, req1_ready);
                end
            end
            step();
        end
        checks++;
        if (i0 != 4 || i1 != 2) begin
            errors++;
            $display("FAIL bubble_count: accepted %0d/%0d, expected 4/2", i0, i1);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_burst_cap();
        test_alternate();
        test_wfull_stall();
        test_reset_mid_tenure();
        test_bubble_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
